cache_port: RTL and testbench
=============================

Name: cache_port

Overview:
- Request/response adapter directly upstream of the SDRAM-backed unified cache.
- Accepts CPU load/store requests (byte/half/word, signed/unsigned) over a valid/ready handshake.
- Converts each request into the cache's word-aligned address, byte write mask and shifted write data.
- Holds all cache inputs stable for the whole busy period plus one cycle, then extracts and extends load data into a one-cycle response.

Parameters:
- TimeoutCycles, 4096, cycles a request may wait on cache_busy before it is aborted with an error response; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  adapter accepts request this cycle
- req_addr  in  32  byte address
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_error  out  1  misaligned, illegal size or timeout
- cache_enable  out  1  to cache enable
- cache_address  out  32  word-aligned address {req_addr[31:2],2'b00}
- cache_data_in  out  32  shifted store data
- cache_write_enable  out  4  byte mask
- cache_data_out  in  32  from cache
- cache_data_out_ready  in  1  from cache
- cache_busy  in  1  from cache

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, cache_enable=0, cache_address=0, cache_data_in=0, cache_write_enable=0, all counters 0, state Idle.
- FSM states: Idle, Settle, Access, Release, Respond. req_ready=1 only in Idle.
- Idle:
  - On req_valid, register the request.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0) or size 11 -> Respond with rsp_error=1. The cache is never enabled.
  - Otherwise drive the cache outputs from registers, cache_enable=1 -> Settle.
- Store mask: byte 4'b0001<<a, half 4'b0011<<a, word 4'b1111, where a=addr[1:0]. Store data is req_wdata<<(8*a).
- Settle: one cycle for the cache's registered tag/column read -> Access.
- Access:
  - A load completes on the first cycle with cache_data_out_ready=1. Capture cache_data_out>>(8*a), then sign- or zero-extend from bit 7 (byte) or bit 15 (half) -> Release.
  - A store completes on the first cycle with cache_busy=0 (the cache writes on that edge) -> Release.
  - The timeout counter increments each Access cycle with cache_busy=1. On reaching TimeoutCycles -> Release with error=1.
- Release: cache outputs held one more cycle (the cache's hold rule), then cache_enable=0 and cache_write_enable=0 -> Respond.
- Respond: rsp_valid=1 for exactly one cycle with rdata/error -> Idle. A new request may be accepted the next cycle.
- Cache outputs never change between Idle exit and the end of Release; req_* inputs are ignored once the request is accepted.
- Hit latency, request accept to rsp_valid: 4 cycles. Misaligned/illegal: 1 cycle.
- rst asserted mid-operation: immediate return to reset values; cache_enable drops asynchronously; no response is issued.

Optional Feature:
- CACHE_PORT_PERF_COUNTERS_EN: adds outputs perf_requests[31:0] (accepted requests), perf_stall_cycles[31:0] (Access cycles with cache_busy=1) and perf_errors[15:0]. Counters wrap at maximum and reset to 0.
- Without the macro the ports and logic are absent; function is otherwise identical.

Decomposition:
- Package cache_port_pkg: size_e enum (SizeByte, SizeHalf, SizeWord), state_e enum, and a function building the mask/shift from size and a.
- Sub-module load_extend: combinational shift plus sign/zero extension of load data.

Test Plan:
- Load byte signed at 0x103, cache holds 0x80FF_0000 at word 0x100, hit -> rsp_rdata=0xFFFF_FF80, rsp_error=0, rsp_valid 4 cycles after accept.
- Store half 0xBEEF to 0x202 -> cache_address=0x200, cache_write_enable=4'b1100, cache_data_in=0xBEEF_0000, held until 1 cycle after cache_busy falls.
- Load word at 0x400 with cache_busy high 20 cycles (miss/eviction) -> outputs stable throughout, rsp_rdata equals line data, perf_stall_cycles +20 with macro enabled.
- Word load at 0x401 -> rsp_error=1 one cycle after accept, cache_enable never asserted.
- TimeoutCycles=8, cache_busy stuck high -> rsp_error=1, rsp_rdata=0, cache_enable low after Release.
- rst pulsed during Access -> cache_enable=0 and req_ready=1 immediately, no rsp_valid pulse.

Source files
------------

// File: rtl/cache_port_pkg.sv
// cache_port_pkg: shared types and lane helper for the cache request adapter.
package cache_port_pkg;

    typedef enum logic [1:0] {SizeByte = 2'b00, SizeHalf = 2'b01, SizeWord = 2'b10} size_e;

    typedef enum logic [2:0] {Idle, Settle, Access, Release, Respond} state_e;

    typedef struct packed {
        logic [3:0] mask;
        logic [4:0] shift;
    } lane_t;

    function automatic lane_t lane_of(size_e size, logic [1:0] a);
        lane_t l;
        l.shift = {a, 3'b000};
        l.mask  = size == SizeWord ? 4'b1111 : size == SizeHalf ? 4'b0011 << a : 4'b0001 << a;
        return l;
    endfunction

endpackage

// File: rtl/cache_port_load_extend.sv
// load_extend: right-aligns the addressed lane of a cache word and sign/zero extends it.
module load_extend
    import cache_port_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  a,
    input  size_e       size,
    input  logic        uns,
    output logic [31:0] rdata
);

    logic [31:0] s;

    assign s     = data >> {a, 3'b000};
    assign rdata = size == SizeByte ? {{24{s[7] & ~uns}}, s[7:0]} :
                   size == SizeHalf ? {{16{s[15] & ~uns}}, s[15:0]} : s;

endmodule

// File: rtl/cache_port.sv
// cache_port: CPU load/store to word-aligned cache adapter with busy watchdog.
// Optional CACHE_PORT_PERF_COUNTERS_EN adds request/stall/error counters.
module cache_port
    import cache_port_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        cache_enable,
    output logic [31:0] cache_address,
    output logic [31:0] cache_data_in,
    output logic [3:0]  cache_write_enable,
    input  logic [31:0] cache_data_out,
    input  logic        cache_data_out_ready,
    input  logic        cache_busy
`ifdef CACHE_PORT_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_requests,
    output logic [31:0] perf_stall_cycles,
    output logic [15:0] perf_errors
`endif
);

    state_e      state, state_nx;
    logic [1:0]  a_q;
    size_e       size_q;
    logic        uns_q, write_q;
    logic [31:0] to_cnt, ext_data;
    logic        bad, done, to_hit;
    lane_t       ln;

    assign ln        = lane_of(size_e'(req_size), req_addr[1:0]);
    assign bad       = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign done      = write_q ? !cache_busy : cache_data_out_ready;
    assign to_hit    = !done && TimeoutCycles != 0 && cache_busy && to_cnt + 32'd1 == TimeoutCycles;
    assign req_ready = state == Idle;
    assign rsp_valid = state == Respond;

    load_extend u_ext (
        .data  (cache_data_out),
        .a     (a_q),
        .size  (size_q),
        .uns   (uns_q),
        .rdata (ext_data)
    );

    always_comb begin
        state_nx = state;
        case (state)
            Idle:    state_nx = req_valid ? (bad ? Respond : Settle) : Idle;
            Settle:  state_nx = Access;
            Access:  state_nx = done || to_hit ? Release : Access;
            Release: state_nx = Respond;
            default: state_nx = Idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= Idle;
            a_q                <= '0;
            size_q             <= SizeByte;
            uns_q              <= 1'b0;
            write_q            <= 1'b0;
            to_cnt             <= '0;
            rsp_rdata          <= '0;
            rsp_error          <= 1'b0;
            cache_enable       <= 1'b0;
            cache_address      <= '0;
            cache_data_in      <= '0;
            cache_write_enable <= '0;
        end else begin
            state <= state_nx;
            case (state)
                Idle: if (req_valid) begin
                    a_q       <= req_addr[1:0];
                    size_q    <= size_e'(req_size);
                    uns_q     <= req_unsigned;
                    write_q   <= req_write;
                    to_cnt    <= '0;
                    rsp_rdata <= '0;
                    rsp_error <= bad;
                    if (!bad) begin
                        cache_enable       <= 1'b1;
                        cache_address      <= {req_addr[31:2], 2'b00};
                        cache_data_in      <= req_wdata << ln.shift;
                        cache_write_enable <= req_write ? ln.mask : 4'b0000;
                    end
                end
                Access: begin
                    if (cache_busy) to_cnt <= to_cnt + 32'd1;
                    if (done) rsp_rdata <= write_q ? 32'd0 : ext_data;
                    if (to_hit) rsp_error <= 1'b1;
                end
                // outputs were held through Release; drop them as we leave it
                Release: begin
                    cache_enable       <= 1'b0;
                    cache_write_enable <= 4'b0000;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_PORT_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_requests     <= '0;
            perf_stall_cycles <= '0;
            perf_errors       <= '0;
        end else begin
            if (state == Idle && req_valid) perf_requests <= perf_requests + 32'd1;
            if (state == Access && cache_busy) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if ((state == Idle && req_valid && bad) || (state == Access && to_hit))
                perf_errors <= perf_errors + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_port.sv
// tb_cache_port: directed bench for cache_port; a second instance with an 8-cycle watchdog.
module tb_cache_port;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0, cache_data_out = '0;
    logic [1:0]  req_size = 2'b00;
    logic        cache_data_out_ready = 1'b0, cache_busy = 1'b0;
    logic        req_ready, rsp_valid, rsp_error, cache_enable;
    logic [31:0] rsp_rdata, cache_address, cache_data_in;
    logic [3:0]  cache_write_enable;
    logic        req_ready_t, rsp_valid_t, rsp_error_t, cache_enable_t;
    logic [31:0] rsp_rdata_t, cache_address_t, cache_data_in_t;
    logic [3:0]  cache_write_enable_t;
`ifdef CACHE_PORT_PERF_COUNTERS_EN
    logic [31:0] perf_requests, perf_stall_cycles, perf_requests_t, perf_stall_cycles_t;
    logic [15:0] perf_errors, perf_errors_t;
    logic [31:0] stall0;
`endif

    int checks = 0, errors = 0;
    int lat, lat_t, en_last;
    logic unstable, s_rdy, r_err, t_err, t_en, bad_rsp;
    logic [31:0] s_addr, s_din, r_data, t_data;
    logic [3:0]  s_we;

    always #5 clk = ~clk;

    cache_port u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .cache_enable(cache_enable),
        .cache_address(cache_address), .cache_data_in(cache_data_in),
        .cache_write_enable(cache_write_enable), .cache_data_out(cache_data_out),
        .cache_data_out_ready(cache_data_out_ready), .cache_busy(cache_busy)
`ifdef CACHE_PORT_PERF_COUNTERS_EN
        , .perf_requests(perf_requests), .perf_stall_cycles(perf_stall_cycles),
        .perf_errors(perf_errors)
`endif
    );

    cache_port #(.TimeoutCycles(8)) u_dut_t (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_t),
        .req_addr(req_addr), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid_t),
        .rsp_rdata(rsp_rdata_t), .rsp_error(rsp_error_t), .cache_enable(cache_enable_t),
        .cache_address(cache_address_t), .cache_data_in(cache_data_in_t),
        .cache_write_enable(cache_write_enable_t), .cache_data_out(cache_data_out),
        .cache_data_out_ready(cache_data_out_ready), .cache_busy(cache_busy)
`ifdef CACHE_PORT_PERF_COUNTERS_EN
        , .perf_requests(perf_requests_t), .perf_stall_cycles(perf_stall_cycles_t),
        .perf_errors(perf_errors_t)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // k counts negedges after the accepting edge; the cache model stalls busy_n Access cycles
    task automatic run(input logic [31:0] addr, input logic wr, input logic [1:0] sz,
                       input logic un, input logic [31:0] wd, input logic [31:0] line,
                       input int busy_n);
        @(negedge clk);
        lat = -1; lat_t = -1; en_last = 0; unstable = 1'b0;
        req_valid = 1'b1; req_addr = addr; req_write = wr; req_size = sz;
        req_unsigned = un; req_wdata = wd; cache_data_out = line;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clk);
            req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
            req_size = 2'($urandom); req_write = 1'($urandom);
            cache_busy = k >= 2 && k <= busy_n + 1;
            cache_data_out_ready = !wr && k == busy_n + 2;
            if (k == 1) begin
                s_addr = cache_address; s_din = cache_data_in; s_we = cache_write_enable;
                s_rdy = req_ready;
            end else if (cache_enable && (cache_address != s_addr || cache_data_in != s_din ||
                         cache_write_enable != s_we)) unstable = 1'b1;
            if (cache_enable) en_last = k;
            if (rsp_valid) begin lat = k; r_data = rsp_rdata; r_err = rsp_error; end
            if (rsp_valid_t && lat_t < 0) begin
                lat_t = k; t_data = rsp_rdata_t; t_err = rsp_error_t; t_en = cache_enable_t;
            end
        end
        cache_busy = 1'b0; cache_data_out_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_error", rsp_error, 0);
        chk("rst_enable", cache_enable, 0);
        chk("rst_addr", cache_address, 0);
        chk("rst_din", cache_data_in, 0);
        chk("rst_we", cache_write_enable, 0);
        rst = 1'b0;

        run(32'h103, 0, 2'b00, 0, 0, 32'h80FF_0000, 0);
        chk("lb_rdata", r_data, 32'hFFFF_FF80);
        chk("lb_err", r_err, 0);
        chk("lb_lat", lat, 4);
        chk("lb_addr", s_addr, 32'h100);
        chk("lb_we", s_we, 0);
        chk("lb_ready_busy", s_rdy, 0);
        chk("lb_en_last", en_last, 3);

        run(32'h202, 1, 2'b01, 0, 32'h0000_BEEF, 0, 3);
        chk("sh_addr", s_addr, 32'h200);
        chk("sh_we", s_we, 4'b1100);
        chk("sh_din", s_din, 32'hBEEF_0000);
        chk("sh_stable", unstable, 0);
        chk("sh_en_last", en_last, 6);
        chk("sh_lat", lat, 7);
        chk("sh_rdata", r_data, 0);

`ifdef CACHE_PORT_PERF_COUNTERS_EN
        stall0 = perf_stall_cycles;
`endif
        run(32'h400, 0, 2'b10, 0, 0, 32'h1234_5678, 20);
        chk("lw_rdata", r_data, 32'h1234_5678);
        chk("lw_stable", unstable, 0);
        chk("lw_lat", lat, 24);
        chk("to_err", t_err, 1);
        chk("to_rdata", t_data, 0);
        chk("to_lat", lat_t, 11);
        chk("to_enable", t_en, 0);
`ifdef CACHE_PORT_PERF_COUNTERS_EN
        chk("perf_stall", perf_stall_cycles - stall0, 20);
        chk("perf_req", perf_requests, 3);
        chk("perf_err_t", perf_errors_t, 1);
`endif

        run(32'h401, 0, 2'b10, 0, 0, 32'h1234_5678, 0);
        chk("mis_err", r_err, 1);
        chk("mis_lat", lat, 1);
        chk("mis_rdata", r_data, 0);
        chk("mis_en", en_last, 0);

        run(32'h203, 0, 2'b01, 1, 0, 0, 0);
        chk("mish_err", r_err, 1);
        run(32'h000, 0, 2'b11, 0, 0, 0, 0);
        chk("ill_err", r_err, 1);
        chk("ill_lat", lat, 1);

        run(32'h102, 0, 2'b01, 1, 0, 32'h80FF_0000, 0);
        chk("lhu_rdata", r_data, 32'h0000_80FF);
        run(32'h102, 0, 2'b01, 0, 0, 32'h80FF_0000, 1);
        chk("lh_rdata", r_data, 32'hFFFF_80FF);
        run(32'h101, 0, 2'b00, 1, 0, 32'h1234_A678, 0);
        chk("lbu_rdata", r_data, 32'h0000_00A6);
        run(32'h301, 1, 2'b00, 0, 32'h0000_005A, 0, 0);
        chk("sb_we", s_we, 4'b0010);
        chk("sb_din", s_din, 32'h0000_5A00);
        run(32'h300, 1, 2'b10, 0, 32'hDEAD_BEEF, 0, 2);
        chk("sw_we", s_we, 4'b1111);
        chk("sw_din", s_din, 32'hDEAD_BEEF);
        chk("sw_err", r_err, 0);

        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h500; req_write = 1'b0; req_size = 2'b10;
        @(negedge clk);
        req_valid = 1'b0; cache_busy = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_enable", cache_enable, 0);
        chk("arst_ready", req_ready, 1);
        chk("arst_rsp", rsp_valid, 0);
        chk("arst_addr", cache_address, 0);
        @(negedge clk);
        rst = 1'b0; cache_busy = 1'b0;
        bad_rsp = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) bad_rsp = 1'b1;
        end
        chk("arst_no_rsp", bad_rsp, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
